// File: rtl/mpemu_descale.sv
// Iterative restoring divider: signed 32-bit product / unsigned 8.24 scale -> signed 24-bit result.
// Define MPEMU_DESCALE_ROUND_EN for round-half-away-from-zero instead of truncation.
module mpemu_descale (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mprod_i,
  input  logic [31:0] scale_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [23:0] mpcand_o,
  output logic        out_valid_o,
  input  logic        out_ack_i
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic        sat_q, sat_d;
  logic [31:0] scale_q, scale_d;
  logic [31:0] rem_q, rem_d;
  logic [23:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] mpcand_q, mpcand_d;
  logic        valid_q, valid_d;

  logic [31:0] mag_in;
  logic        ovf;
  logic [32:0] rem_sh;
  logic        take;
  logic [31:0] rem_nxt;
  logic [23:0] quot_nxt;
  logic [23:0] mag_fin;
  logic        sat_fin;
  logic [23:0] result;

  always_comb begin
    mag_in   = mprod_i[31] ? (~mprod_i + 32'd1) : mprod_i;
    ovf      = {mag_in, 1'b0} >= {1'b0, scale_i};
    rem_sh   = {rem_q, 1'b0};
    take     = rem_sh >= {1'b0, scale_q};
    // When take is set the difference is below scale, so 32 bits hold it exactly.
    rem_nxt  = take ? (rem_sh[31:0] - scale_q) : rem_sh[31:0];
    quot_nxt = {quot_q[22:0], take};
`ifdef MPEMU_DESCALE_ROUND_EN
    mag_fin  = quot_nxt + {23'd0, ({rem_nxt, 1'b0} >= {1'b0, scale_q})};
`else
    mag_fin  = quot_nxt;
`endif
    // A rounded magnitude reaching 2^23 clamps like an overflow.
    sat_fin  = sat_q | mag_fin[23];
    if (sat_fin) begin
      result = sign_q ? 24'h800000 : 24'h7fffff;
    end else begin
      result = sign_q ? (~mag_fin + 24'd1) : mag_fin;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    sat_d    = sat_q;
    scale_d  = scale_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    mpcand_d = mpcand_q;
    valid_d  = valid_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sign_d  = mprod_i[31];
          scale_d = scale_i;
          sat_d   = ovf;
          rem_d   = mag_in;
          quot_d  = 24'd0;
          // Saturation takes a single pass through StDiv so its result lands one edge later.
          cnt_d   = ovf ? 5'd0 : 5'd23;
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d  = rem_nxt;
        quot_d = quot_nxt;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          mpcand_d = result;
          valid_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ack_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      sat_q    <= 1'b0;
      scale_q  <= 32'd0;
      rem_q    <= 32'd0;
      quot_q   <= 24'd0;
      cnt_q    <= 5'd0;
      mpcand_q <= 24'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      sat_q    <= sat_d;
      scale_q  <= scale_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      mpcand_q <= mpcand_d;
      valid_q  <= valid_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign mpcand_o    = mpcand_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_mpemu_descale.sv
// Directed self-checking bench for mpemu_descale.
module tb_mpemu_descale;

  logic        clk;
  logic        rst;
  logic [31:0] mprod;
  logic [31:0] scale;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mpcand;
  logic        out_valid;
  logic        out_ack;

  int checks;
  int failures;

  mpemu_descale dut (
    .clk         (clk),
    .rst         (rst),
    .mprod_i     (mprod),
    .scale_i     (scale),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mpcand_o    (mpcand),
    .out_valid_o (out_valid),
    .out_ack_i   (out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from IDLE; lat counts edges after the accept edge until out_valid is seen.
  task automatic do_req(input logic [31:0] p, input logic [31:0] s,
                        output int lat, output logic [23:0] res);
    @(negedge clk);
    mprod    = p;
    scale    = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mprod    = $urandom;
    scale    = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = mpcand;
  endtask

  task automatic do_ack();
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (mpcand !== 24'h000000) begin
      failures++;
      $display("FAIL reset_mpcand got=%h want=000000", mpcand);
    end
  endtask

  task automatic test_normal();
    logic [31:0] p_tab [5];
    logic [31:0] s_tab [5];
    logic [23:0] e_tab [5];
    int          lat;
    logic [23:0] res;
    p_tab = '{32'h00123456, 32'h002468ac, 32'hffffffff, 32'hfffffffe, 32'h00000003};
    s_tab = '{32'h01000000, 32'h02000000, 32'h01000000, 32'h02000000, 32'h02000000};
`ifdef MPEMU_DESCALE_ROUND_EN
    e_tab = '{24'h123456, 24'h123456, 24'hffffff, 24'hffffff, 24'h000002};
`else
    e_tab = '{24'h123456, 24'h123456, 24'hffffff, 24'hffffff, 24'h000001};
`endif
    for (int i = 0; i < 5; i++) begin
      do_req(p_tab[i], s_tab[i], lat, res);
      checks++;
      if (res !== e_tab[i]) begin
        failures++;
        $display("FAIL normal_result[%0d] got=%h want=%h", i, res, e_tab[i]);
      end
      checks++;
      if (lat != 24) begin
        failures++;
        $display("FAIL normal_latency[%0d] got=%0d want=24", i, lat);
      end
      do_ack();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL normal_ack[%0d] got valid=%b ready=%b want valid=0 ready=1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] p_tab [3];
    logic [31:0] s_tab [3];
    logic [23:0] e_tab [3];
    int          lat;
    logic [23:0] res;
    p_tab = '{32'h00800000, 32'h80000000, 32'h00000000};
    s_tab = '{32'h01000000, 32'h01000000, 32'h00000000};
    e_tab = '{24'h7fffff, 24'h800000, 24'h7fffff};
    for (int i = 0; i < 3; i++) begin
      do_req(p_tab[i], s_tab[i], lat, res);
      checks++;
      if (res !== e_tab[i]) begin
        failures++;
        $display("FAIL sat_result[%0d] got=%h want=%h", i, res, e_tab[i]);
      end
      checks++;
      if (lat != 1) begin
        failures++;
        $display("FAIL sat_latency[%0d] got=%0d want=1", i, lat);
      end
      do_ack();
    end
  endtask

  task automatic test_handshake();
    int          lat;
    logic [23:0] res;
    do_req(32'h002468ac, 32'h02000000, lat, res);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      // A request while DONE must be dropped.
      mprod    = 32'h00000100;
      scale    = 32'h01000000;
      in_valid = (c == 1);
      @(posedge clk);
      #1;
      checks++;
      if (mpcand !== 24'h123456 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] got mpcand=%h valid=%b ready=%b want 123456/1/0",
                 c, mpcand, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    do_ack();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL no_queue got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [23:0] res;
    @(negedge clk);
    mprod    = 32'h00123456;
    scale    = 32'h01000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mpcand !== 24'h000000) begin
      failures++;
      $display("FAIL mid_reset got ready=%b valid=%b mpcand=%h want 1/0/000000",
               in_ready, out_valid, mpcand);
    end
    @(negedge clk);
    rst = 1'b0;
    do_req(32'hffedcbaa, 32'h01000000, lat, res);
    checks++;
    if (res !== 24'hedcbaa || lat != 24) begin
      failures++;
      $display("FAIL after_reset got=%h lat=%0d want=edcbaa lat=24", res, lat);
    end
    do_ack();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mprod    = 32'd0;
    scale    = 32'd0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_normal();
    test_saturate();
    test_handshake();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpemu_descale.md
# mpemu_descale

Iterative inverse of the 8.24 fixed-point scaler: takes a signed 32-bit product and an unsigned 8.24 scale, and returns the signed 24-bit multiplicand such that multiplicand × scale ≈ product. Sits in the mixer's gain-compensation path, where divides are rare, so it uses a one-bit-per-cycle restoring divider instead of a pipeline. Inputs use a ready/valid handshake; the result is held until acknowledged.

## Interface
- No parameters.
- `clk`  in  1  system clock (24.576 MHz); all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mprod_i`  in  32  signed product (two's complement).
- `scale_i`  in  32  unsigned scale, 8.24 (`32'h01_000000` = 1.0).
- `in_valid_i`  in  1  request; sampled with `mprod_i` and `scale_i`.
- `in_ready_o`  out  1  high only in IDLE.
- `mpcand_o`  out  24  signed result; stable while `out_valid_o`=1.
- `out_valid_o`  out  1  result available.
- `out_ack_i`  in  1  consumer accepts the result.

## Operation
- States: IDLE, DIV, DONE.
- Reset state: IDLE. Output reset values: `in_ready_o`=1, `out_valid_o`=0, `mpcand_o`=0. Counter, remainder and quotient registers reset to 0.
- `in_ready_o` = (state==IDLE), combinational.
- **IDLE, `in_valid_i`=1:**
  - Latch sign = `mprod_i[31]`, |p| = magnitude as a 32-bit unsigned value (−2^31 → 2^31), and s = `scale_i`.
  - Overflow test: saturate if 2·|p| ≥ s (33-bit compare). This includes s=0.
    - Saturate: go to DONE. `mpcand_o` = 24'h7fffff if sign=0, else 24'h800000.
    - Otherwise: remainder = |p|, quotient = 0, counter = 23, go to DIV.
- **DIV, each cycle:**
  - r' = remainder<<1 (33 bits).
  - If r' ≥ s: remainder = r'−s and shift 1 into the quotient LSB; else remainder = r' and shift 0.
  - Decrement the counter. On the step with counter=0, the final 24-bit magnitude is formed:
    - Negate it if sign=1 and write `mpcand_o`.
    - Go to DONE with `out_valid_o`=1 on the same edge.
- **Result rule:** magnitude = floor(|p|·2^24 / s), truncated toward zero, then the sign is applied. No saturation is possible on this path because magnitude < 2^23.
- **DONE:** hold `mpcand_o` and `out_valid_o`=1 until `out_ack_i`=1. On that edge go to IDLE and clear `out_valid_o`. `mpcand_o` keeps its last value.
- `in_valid_i` outside IDLE is ignored; there is no queueing.
- `out_ack_i` outside DONE is ignored.
- Input ports are not required to be stable after the accept edge.
- `rst` asserted in any state, including mid-DIV, forces IDLE and the reset values immediately. The partial result is discarded.

## Timing
- Accept edge E: `in_valid_i`=1 while IDLE.
- Normal path: 24 DIV cycles. `out_valid_o`=1 after edge E+24.
- Saturating path: `out_valid_o`=1 after edge E+1.
- Ack at edge A: `out_valid_o`=0 and `in_ready_o`=1 after A. The earliest next accept is edge A+1.
- Back-to-back throughput (normal path, ack in the first DONE cycle): one result per 26 cycles.

## Configuration
- `MPEMU_DESCALE_ROUND_EN` defined: on the final DIV step, if 2·(final remainder) ≥ s, the magnitude is incremented before the sign is applied. This is round half away from zero.
  - An incremented magnitude of 2^23 clamps to 24'h7fffff / 24'h800000 according to sign.
  - Latency is unchanged.
- Undefined: truncation toward zero as described in Operation.

## Test plan
- p=32'h00123456, s=32'h01000000 → `mpcand_o`=24'h123456; `out_valid_o` rises exactly 24 cycles after accept.
- p=32'h002468ac, s=32'h02000000 → 24'h123456.
- p=32'hffffffff, s=32'h01000000 → 24'hffffff. Also p=32'hfffffffe, s=32'h02000000 → 24'hffffff.
- p=32'h00000003, s=32'h02000000:
  - Macro undefined → 24'h000001.
  - Macro defined → 24'h000002.
- Saturation, each with `out_valid_o` one cycle after accept:
  - p=32'h00800000, s=32'h01000000 → 24'h7fffff.
  - p=32'h80000000, s=32'h01000000 → 24'h800000.
  - p=0, s=0 → 24'h7fffff.
- Handshake and reset:
  - Hold `out_ack_i`=0 for 5 cycles → result stable and `in_ready_o`=0; a request issued in DONE is ignored.
  - Assert `rst` at DIV step 10 → immediately IDLE with `out_valid_o`=0.
  - A fresh request after reset completes with the correct result.
